vector_alu_pipe: RTL and testbench

Parametrised, handshaked successor to the combinational `alu`: the same 4-bit opcode set, but over `LANES` lanes of `LANE_W` bits, with a registered output and valid/ready flow control. `MULT` becomes an iterative multi-cycle operation, and per-lane zero flags are added. The block sits in the execute stage between operand read and write-back. It stalls upstream while a multiply is in progress or while its result is held.

---
 rtl/vector_alu_pkg.sv | 31 +++
 rtl/vector_alu_pipe_seq_multiplier.sv | 61 ++++++
 rtl/vector_alu_pipe.sv | 156 +++++++++++++++
 tb/tb_vector_alu_pipe.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_alu_pkg.sv
// Shared types for the vector ALU: opcode encodings, pipeline states and a
// helper that locates a lane inside a packed vector.
package vector_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_MULT = 4'b0010,
    OP_XOR  = 4'b0011,
    OP_ADDV = 4'b0100,
    OP_SUBV = 4'b0101,
    OP_XORV = 4'b0110,
    OP_SLV  = 4'b0111,
    OP_SRV  = 4'b1000,
    OP_SCLV = 4'b1001,
    OP_SCRV = 4'b1010,
    OP_NOP  = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE,
    FULL,
    MUL
  } state_e;

  // Bit position of the least significant bit of a lane.
  function automatic int lane_lsb(input int lane, input int lane_w);
    return lane * lane_w;
  endfunction

endpackage

// File: rtl/vector_alu_pipe_seq_multiplier.sv
// Radix-2 shift-add multiplier: one partial product per cycle for WIDTH
// cycles, keeping the low WIDTH bits of the unsigned product.
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_step;

  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign busy     = (cnt_q != '0);
  // The final step's sum is offered combinationally so the caller can load
  // it on the same edge the counter terminates.
  assign done     = (cnt_q == WIDTH'(1));
  assign product  = acc_step;

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start) begin
      cnt_d    = WIDTH'(WIDTH);
      acc_d    = '0;
      mcand_d  = op_a;
      mplier_d = op_b;
    end else if (busy) begin
      cnt_d    = cnt_q - WIDTH'(1);
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/vector_alu_pipe.sv
// Execute-stage vector ALU with a registered, handshaked result and an
// iterative multiply.
//   state | meaning
//   IDLE  | no result held, ready for a new op
//   FULL  | result held on ALU_OUT/FLAGS, ready only when it drains
//   MUL   | multiply iterating, upstream stalled
module vector_alu_pipe
  import vector_alu_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int LANE_W = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  input  logic [LANES*LANE_W-1:0]    SRC_A,
  input  logic [LANES*LANE_W-1:0]    SRC_B,
  input  logic [3:0]                 ALU_CONTROL,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [LANES*LANE_W-1:0]    ALU_OUT,
  output logic [LANES-1:0]           FLAGS
);

  localparam int WIDTH = LANES * LANE_W;
  localparam int SH_W  = $clog2(LANE_W);

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  alu_q, alu_d;
  logic [LANES-1:0]  flags_q, flags_d, zero_d;
  logic              load, accept, drain, is_single, mul_start;
  logic              mul_busy, mul_done;
  logic [WIDTH-1:0]  mul_product, lane_res, op_res;
  logic [SH_W-1:0]   shamt;
  opcode_e           op;

  assign op     = opcode_e'(ALU_CONTROL);
  assign shamt  = SRC_B[SH_W-1:0];
  assign accept = IN_VALID & IN_READY;
  assign drain  = out_valid_q & OUT_READY;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int LSB = lane_lsb(i, LANE_W);
    logic [LANE_W-1:0] la, lb, res;
    assign la = SRC_A[LSB +: LANE_W];
    assign lb = SRC_B[LSB +: LANE_W];
    always_comb begin
      res = '0;
      case (op)
        OP_ADDV: res = la + lb;
        OP_SUBV: res = la - lb;
        OP_XORV: res = la ^ lb;
        OP_SLV:  res = la << shamt;
        OP_SRV:  res = la >> shamt;
        OP_SCLV: res = (la << shamt) | (la >> (LANE_W - int'(shamt)));
        OP_SCRV: res = (la >> shamt) | (la << (LANE_W - int'(shamt)));
        default: res = '0;
      endcase
    end
    assign lane_res[LSB +: LANE_W] = res;
    assign zero_d[i] = ~|alu_d[LSB +: LANE_W];
  end

  always_comb begin
    op_res    = lane_res;
    is_single = 1'b1;
    case (op)
      OP_ADD:  op_res = SRC_A + SRC_B;
      OP_SUB:  op_res = SRC_A - SRC_B;
      OP_XOR:  op_res = SRC_A ^ SRC_B;
      OP_ADDV, OP_SUBV, OP_XORV, OP_SLV, OP_SRV, OP_SCLV, OP_SCRV: is_single = 1'b1;
      default: is_single = 1'b0;
    endcase
  end

  seq_multiplier #(.WIDTH(WIDTH)) u_mult (
    .clk_sys (CLK),
    .rst     (RST),
    .start   (mul_start),
    .op_a    (SRC_A),
    .op_b    (SRC_B),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Next state; a drain in FULL falls through to the IDLE accept path so
  // back-to-back ops issue every cycle.
  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    case (state_q)
      IDLE, FULL: begin
        if (drain) state_d = IDLE;
        if (accept) begin
          if (op == OP_MULT) begin
            mul_start = 1'b1;
            state_d   = MUL;
          end else if (is_single) begin
            state_d = FULL;
          end
        end
      end
      MUL: if (mul_busy && mul_done) state_d = FULL;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_d = alu_q;
    load  = 1'b0;
    if (state_q == MUL) begin
      if (mul_busy && mul_done) begin
        alu_d = mul_product;
        load  = 1'b1;
      end
    end else if (accept && is_single) begin
      alu_d = op_res;
      load  = 1'b1;
    end
    flags_d     = load ? zero_d : flags_q;
    out_valid_d = (state_d == FULL);
  end

  always_comb begin
    IN_READY = 1'b0;
    if (!RST) begin
      case (state_q)
        IDLE:    IN_READY = 1'b1;
        FULL:    IN_READY = OUT_READY;
        default: IN_READY = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      alu_q       <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      alu_q       <= alu_d;
      flags_q     <= flags_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign ALU_OUT   = alu_q;
  assign FLAGS     = flags_q;

endmodule

// File: tb/tb_vector_alu_pipe.sv
// Scoreboard bench: drives a 4x8 and an 8x4 instance with the same operations
// and checks both against a lane-arithmetic reference model.
module tb_vector_alu_pipe;

  logic        clk, rst, v0, v1, rdy0, rdy1, ordy, ov0, ov1;
  logic [31:0] src_a, src_b, alu0, alu1;
  logic [3:0]  ctl, fl0;
  logic [7:0]  fl1;
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          rand_ordy = 0;
  logic        ordy_dir  = 1'b1;

  typedef struct {
    logic [31:0] r;
    logic [7:0]  f;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  vector_alu_pipe #(.LANES(4), .LANE_W(8)) dut0 (
    .CLK(clk), .RST(rst), .IN_VALID(v0), .IN_READY(rdy0), .SRC_A(src_a), .SRC_B(src_b),
    .ALU_CONTROL(ctl), .OUT_VALID(ov0), .OUT_READY(ordy), .ALU_OUT(alu0), .FLAGS(fl0));

  vector_alu_pipe #(.LANES(8), .LANE_W(4)) dut1 (
    .CLK(clk), .RST(rst), .IN_VALID(v1), .IN_READY(rdy1), .SRC_A(src_a), .SRC_B(src_b),
    .ALU_CONTROL(ctl), .OUT_VALID(ov1), .OUT_READY(ordy), .ALU_OUT(alu1), .FLAGS(fl1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial ordy = 1'b1;
  always @(posedge clk) begin
    #1;
    ordy = rand_ordy ? ($urandom_range(0, 3) != 0) : ordy_dir;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input int lanes, input int lw,
                                output logic [31:0] r, output logic [7:0] f, output bit has);
    int unsigned mask, x, y, s, o;
    mask = (32'd1 << lw) - 1;
    r = '0;
    f = '0;
    has = 1'b1;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd3: r = a ^ b;
      4'd2: r = 32'(64'(a) * 64'(b));
      4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10: begin
        s = b % lw;
        for (int i = 0; i < lanes; i++) begin
          x = (a >> (i * lw)) & mask;
          y = (b >> (i * lw)) & mask;
          o = 0;
          case (op)
            4'd4: o = x + y;
            4'd5: o = x - y;
            4'd6: o = x ^ y;
            4'd7: o = x << s;
            4'd8: o = x >> s;
            4'd9: begin
              o = x;
              for (int k = 0; k < int'(s); k++) o = ((o << 1) | (o >> (lw - 1))) & mask;
            end
            default: begin
              o = x;
              for (int k = 0; k < int'(s); k++) o = (o >> 1) | ((o & 1) << (lw - 1));
            end
          endcase
          r = r | ((o & mask) << (i * lw));
        end
      end
      default: has = 1'b0;
    endcase
    for (int i = 0; i < lanes; i++) f[i] = (((r >> (i * lw)) & mask) == 0);
  endfunction

  always @(negedge clk) begin
    if (!rst && ov0 && ordy) begin
      if (q0.size() == 0) check("unexpected_out_4x8", ov0, 1'b0);
      else begin
        e0 = q0.pop_front();
        check("alu_out_4x8", alu0, e0.r);
        check("flags_4x8", fl0, e0.f[3:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ov1 && ordy) begin
      if (q1.size() == 0) check("unexpected_out_8x4", ov1, 1'b0);
      else begin
        e1 = q1.pop_front();
        check("alu_out_8x4", alu1, e1.r);
        check("flags_8x4", fl1, e1.f);
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 after both instances accepted.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int cyc);
    logic [31:0] r;
    logic [7:0]  f;
    bit          h, r0, r1;
    model(op, a, b, 4, 8, r, f, h);
    if (h) q0.push_back('{r, f});
    model(op, a, b, 8, 4, r, f, h);
    if (h) q1.push_back('{r, f});
    src_a = a;
    src_b = b;
    ctl   = op;
    v0    = 1'b1;
    v1    = 1'b1;
    cyc   = 0;
    while ((v0 || v1) && cyc < 200) begin
      @(negedge clk);
      r0 = rdy0;
      r1 = rdy1;
      @(posedge clk);
      #1;
      if (r0) v0 = 1'b0;
      if (r1) v1 = 1'b0;
      cyc++;
    end
    if (v0 || v1) check("accept_timeout", {v0, v1}, 2'b00);
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("queues_drained", q0.size() + q1.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          c, n, tot;
    logic [31:0] r;
    logic [7:0]  f;
    bit          h;
    logic [3:0]  op;
    logic [31:0] a, b;

    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; src_a = '0; src_b = '0; ctl = '0;
    @(negedge clk);
    check("in_ready_in_reset_4x8", rdy0, 1'b0);
    check("in_ready_in_reset_8x4", rdy1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {ov0, ov1}, 2'b00);
    check("rst_alu_out", {alu0, alu1}, 64'h0);
    check("rst_flags", {fl0, fl1}, 12'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", {rdy0, rdy1}, 2'b11);
    @(posedge clk); #1;

    issue(4'b0000, 32'd4, 32'd100, c);
    @(negedge clk);
    check("add_one_cycle_latency", ov0, 1'b1);
    @(posedge clk); #1;
    issue(4'b0001, 32'd4, 32'd100, c);
    issue(4'b0100, 32'h01FF7F80, 32'h01010101, c);
    issue(4'b0101, 32'h00000000, 32'h01010101, c);
    for (int bi = 0; bi < 2; bi++)
      for (int o = 7; o <= 10; o++) issue(4'(o), 32'd254, (bi == 0) ? 32'd4 : 32'd12, c);

    issue(4'b0010, 32'd4, 32'd100, c);
    n = 0;
    @(negedge clk);
    while (!rdy0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("mult_in_ready_low_cycles", n, 32);
    @(posedge clk); #1;
    issue(4'b0010, 32'hFFFFFFFF, 32'd2, c);
    wait_empty();

    ordy_dir = 1'b0;
    @(posedge clk); #1;
    issue(4'b0000, 32'h12345678, 32'h11111111, c);
    model(4'b0000, 32'h12345678, 32'h11111111, 4, 8, r, f, h);
    src_a = 32'hA5A5A5A5; src_b = 32'h5A5A5A5A; ctl = 4'b0011; v0 = 1'b1; v1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_in_ready", {rdy0, rdy1}, 2'b00);
      check("stall_alu_out_stable", alu0, r);
    end
    ordy_dir = 1'b1;
    @(posedge clk); #1;
    issue(4'b0011, 32'hA5A5A5A5, 32'h5A5A5A5A, c);
    check("drain_and_accept_same_cycle", c, 1);

    tot = 0;
    for (int k = 0; k < 4; k++) begin
      issue(4'b0110, $urandom, $urandom, c);
      tot += c;
    end
    check("xorv_stream_cycles", tot, 4);
    issue(4'b1111, 32'd1, 32'd2, c);
    check("nop_accept_cycles", c, 1);
    issue(4'b1100, 32'd3, 32'd4, c);
    check("undef_accept_cycles", c, 1);
    @(negedge clk);
    check("nop_no_out_valid", {ov0, ov1}, 2'b00);
    @(posedge clk); #1;

    issue(4'b0010, 32'd1234, 32'd5678, c);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    q0.delete();
    q1.delete();
    @(posedge clk);
    @(negedge clk);
    check("mul_abort_out_valid", {ov0, ov1}, 2'b00);
    check("mul_abort_alu_out", {alu0, alu1}, 64'h0);
    check("mul_abort_flags", {fl0, fl1}, 12'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (ov0 || ov1) n++;
    end
    check("mul_abort_no_result", n, 0);
    @(posedge clk); #1;

    rand_ordy = 1;
    for (int k = 0; k < 150; k++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) a = a & 32'hFF00F0F0;
      if ($urandom_range(0, 3) == 0) b = a;
      issue(op, a, b, c);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
    end
    rand_ordy = 0;
    ordy_dir  = 1'b1;
    wait_empty();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
